axi_apb_req_arb: RTL and testbench
==================================

Name: axi_apb_req_arb

Overview:
- Shares the bridge's single request FIFO between the AXI write-address (AW) and read-address (AR) channels.
- Arbitrates the two channels, packs each accepted request into one command word and holds it in a one-entry staging register.
- Pushes the staged word into the request FIFO whenever the FIFO is not full.
- Tracks outstanding transactions against a limit, so the APB side never receives more than MAX_OUTST pending commands.

Parameters:
- ADDR_WIDTH, 32, AXI address width.
- ID_WIDTH, 4, AXI ID width.
- LEN_WIDTH, 8, AXI burst length field width.
- MAX_OUTST, 8, maximum accepted-but-not-completed transactions (1..2**CNT_WIDTH-1).
- CNT_WIDTH, 4, width of the outstanding counter.
- CMD_WIDTH, 1+ID_WIDTH+ADDR_WIDTH+LEN_WIDTH, packed command width (derived).

Ports:
- wclk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- awvalid  in  1  AW request valid
- awready  out  1  AW accepted this cycle
- awid  in  ID_WIDTH  write ID
- awaddr  in  ADDR_WIDTH  write address
- awlen  in  LEN_WIDTH  write burst length
- arvalid  in  1  AR request valid
- arready  out  1  AR accepted this cycle
- arid  in  ID_WIDTH  read ID
- araddr  in  ADDR_WIDTH  read address
- arlen  in  LEN_WIDTH  read burst length
- fifo_full  in  1  request FIFO full
- fifo_wr  out  1  push strobe to request FIFO
- fifo_wdata  out  CMD_WIDTH  command word {is_wr, id, addr, len}, is_wr at MSB
- txn_done  in  1  one-cycle pulse from the APB side: one transaction retired
- outst_cnt  out  CNT_WIDTH  current outstanding count
- busy  out  1  staging register occupied or outst_cnt != 0

Behaviour:
- Reset values: hold_vld=0, hold_data=0, last_gnt=read (so write wins the first tie), outst_cnt=0. Outputs at reset: awready=0, arready=0, fifo_wr=0, fifo_wdata=0, busy=0.
- State machine has two states, derived from hold_vld:
  - EMPTY (hold_vld=0) goes to HOLD on accept.
  - HOLD (hold_vld=1) goes to EMPTY on push without a same-cycle accept.
  - HOLD stays in HOLD on push with a same-cycle accept.
- push = hold_vld & ~fifo_full.
- fifo_wr = push, combinational; fifo_wdata = hold_data.
- can_acc = (~hold_vld | push) & (outst_cnt < MAX_OUTST).
- Grant, round-robin:
  - Both valid: grant the channel opposite last_gnt.
  - One valid: grant that channel.
  - None valid: no grant.
- awready = can_acc & gnt_aw; arready = can_acc & gnt_ar. Ready may depend on valid. The two readies are never high together.
- Accept (valid & ready):
  - hold_data <= packed request (is_wr=1 for AW, 0 for AR).
  - hold_vld <= 1.
  - last_gnt <= granted channel.
  - The new word is visible on fifo_wdata the next cycle.
- Latency: an accept in cycle N gives fifo_wr in cycle N+1 at the earliest.
- Sustained throughput is one command per cycle while the FIFO has space.
- Outstanding counter:
  - outst_cnt increments on accept and decrements on txn_done.
  - Simultaneous accept and txn_done leaves it unchanged.
  - txn_done with outst_cnt=0 is ignored; the counter stays at 0 and does not wrap.
- Limit: when outst_cnt == MAX_OUTST both readies are 0. The staged word is still pushed.
- FIFO full: hold_data is stable and fifo_wr=0. A new accept happens only when the staging register frees in the same cycle.
- Reset mid-operation: the staged word and the count are discarded immediately (asynchronous), and all outputs return to their reset values.
- Valid without ready: the request is not consumed and the arbiter state is unchanged.

Optional Feature:
- Macro: WR_PRIO_EN.
- Defined: fixed priority; the AW channel always wins when both channels are valid, and last_gnt is unused.
- Undefined (default): round-robin as described in Behaviour.

Test Plan:
- Basic push: after reset, AW only, awaddr=0x1000, awid=3, awlen=0.
  - awready=1 in cycle 0.
  - Cycle 1: fifo_wr=1, fifo_wdata={1,3,0x00001000,0}, outst_cnt=1.
- Tie-break: awvalid and arvalid held high for 4 accepts, FIFO never full.
  - Grant order AW,AR,AW,AR; outst_cnt=4.
  - With WR_PRIO_EN: AW,AW,AW,AW.
- FIFO full stall: fifo_full=1 for 5 cycles with a word staged.
  - fifo_wr=0 and fifo_wdata stable; a second valid sees ready=0.
  - fifo_full drops: push and the second accept occur in the same cycle.
- Outstanding limit: MAX_OUTST=8, 8 accepts, no txn_done.
  - Readies stay 0 with valids high.
  - One txn_done pulse: exactly one further accept, outst_cnt returns to 8.
- Counter corner cases:
  - txn_done coincident with accept: outst_cnt unchanged.
  - txn_done with outst_cnt=0: stays 0.
- Reset mid-operation: assert rst_n=0 with hold_vld=1 and outst_cnt=5.
  - Asynchronously: fifo_wr=0, outst_cnt=0, busy=0.
  - First grant after release goes to AW on a tie.

Source files
------------

// File: rtl/axi_apb_req_arb.sv
// AW/AR request arbiter feeding the shared request FIFO through a one-entry staging register; accept->fifo_wr is 1 cycle, one command/cycle.
// Readies drop while staging cannot free or MAX_OUTST are pending. Define WR_PRIO_EN for fixed AW priority instead of round-robin.
module axi_apb_req_arb #(
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int LEN_WIDTH  = 8,
    parameter int MAX_OUTST  = 8,
    parameter int CNT_WIDTH  = 4,
    parameter int CMD_WIDTH  = 1 + ID_WIDTH + ADDR_WIDTH + LEN_WIDTH
) (
    input  logic                  wclk,
    input  logic                  rst_n,

    input  logic                  awvalid,
    output logic                  awready,
    input  logic [ID_WIDTH-1:0]   awid,
    input  logic [ADDR_WIDTH-1:0] awaddr,
    input  logic [LEN_WIDTH-1:0]  awlen,

    input  logic                  arvalid,
    output logic                  arready,
    input  logic [ID_WIDTH-1:0]   arid,
    input  logic [ADDR_WIDTH-1:0] araddr,
    input  logic [LEN_WIDTH-1:0]  arlen,

    input  logic                  fifo_full,
    output logic                  fifo_wr,
    output logic [CMD_WIDTH-1:0]  fifo_wdata,

    input  logic                  txn_done,
    output logic [CNT_WIDTH-1:0]  outst_cnt,
    output logic                  busy
);

    typedef struct packed {
        logic                  is_wr;
        logic [ID_WIDTH-1:0]   id;
        logic [ADDR_WIDTH-1:0] addr;
        logic [LEN_WIDTH-1:0]  len;
    } cmd_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LP_MAX_OUTST = CNT_WIDTH'(MAX_OUTST);

    state_t               r_state;
    state_t               w_state_nxt;
    cmd_t                 r_hold_data;
    logic [CNT_WIDTH-1:0] r_outst_cnt;

    logic w_hold_vld;
    logic w_push;
    logic w_can_acc;
    logic w_gnt_aw;
    logic w_gnt_ar;
    logic w_acc_aw;
    logic w_acc_ar;
    logic w_acc;
    logic w_dec;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: if (w_acc)            w_state_nxt = ST_HOLD;
            ST_HOLD:  if (w_push && !w_acc) w_state_nxt = ST_EMPTY;
            default:                        w_state_nxt = ST_EMPTY;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        w_hold_vld = (r_state == ST_HOLD);
        w_push     = w_hold_vld & ~fifo_full;
        // The staging slot may be refilled in the same cycle it drains.
        w_can_acc  = (~w_hold_vld | w_push) & (r_outst_cnt < LP_MAX_OUTST);
        awready    = w_can_acc & w_gnt_aw;
        arready    = w_can_acc & w_gnt_ar;
        w_acc_aw   = awvalid & awready;
        w_acc_ar   = arvalid & arready;
        w_acc      = w_acc_aw | w_acc_ar;
        fifo_wr    = w_push;
        fifo_wdata = r_hold_data;
        busy       = w_hold_vld | (r_outst_cnt != '0);
        outst_cnt  = r_outst_cnt;
    end

`ifdef WR_PRIO_EN
    always_comb begin
        w_gnt_aw = awvalid;
        w_gnt_ar = arvalid & ~awvalid;
    end
`else
    logic r_last_gnt_wr;

    // Ties go to the channel not served last; reset state favours AW.
    always_comb begin
        w_gnt_aw = 1'b0;
        w_gnt_ar = 1'b0;
        if (awvalid && arvalid) begin
            w_gnt_aw = ~r_last_gnt_wr;
            w_gnt_ar = r_last_gnt_wr;
        end else begin
            w_gnt_aw = awvalid;
            w_gnt_ar = arvalid;
        end
    end

    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_gnt_wr <= 1'b0;
        end else if (w_acc) begin
            r_last_gnt_wr <= w_acc_aw;
        end
    end
`endif

    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_data <= '0;
        end else if (w_acc_aw) begin
            r_hold_data <= '{is_wr: 1'b1, id: awid, addr: awaddr, len: awlen};
        end else if (w_acc_ar) begin
            r_hold_data <= '{is_wr: 1'b0, id: arid, addr: araddr, len: arlen};
        end
    end

    // Stray retire pulses at zero are dropped rather than wrapping.
    assign w_dec = txn_done & (r_outst_cnt != '0);

    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            r_outst_cnt <= '0;
        end else begin
            case ({w_acc, w_dec})
                2'b10:   r_outst_cnt <= r_outst_cnt + 1'b1;
                2'b01:   r_outst_cnt <= r_outst_cnt - 1'b1;
                default: r_outst_cnt <= r_outst_cnt;
            endcase
        end
    end

    a_one_ready: assert property (@(posedge wclk) disable iff (!rst_n)
        !(awready && arready));
    a_cnt_limit: assert property (@(posedge wclk) disable iff (!rst_n)
        r_outst_cnt <= LP_MAX_OUTST);
    a_full_stable: assert property (@(posedge wclk) disable iff (!rst_n)
        (w_hold_vld && fifo_full && !w_acc) |=> $stable(r_hold_data));

endmodule

// File: tb/tb_axi_apb_req_arb.sv
// Directed stimulus with a scoreboard queue of expected command words, checked by an independent FIFO-write monitor.
module tb_axi_apb_req_arb;

    localparam int CMD_W = 45;

    logic              wclk = 1'b0;
    logic              rst_n = 1'b0;
    logic              awvalid = 1'b0, arvalid = 1'b0;
    logic              awready, arready;
    logic [3:0]        awid = '0, arid = '0;
    logic [31:0]       awaddr = '0, araddr = '0;
    logic [7:0]        awlen = '0, arlen = '0;
    logic              fifo_full = 1'b0;
    logic              fifo_wr;
    logic [CMD_W-1:0]  fifo_wdata;
    logic              txn_done = 1'b0;
    logic [3:0]        outst_cnt;
    logic              busy;

    int errors = 0;
    int checks = 0;
    logic [CMD_W-1:0] exp_q[$];

    axi_apb_req_arb dut (
        .wclk(wclk), .rst_n(rst_n),
        .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr), .awlen(awlen),
        .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr), .arlen(arlen),
        .fifo_full(fifo_full), .fifo_wr(fifo_wr), .fifo_wdata(fifo_wdata),
        .txn_done(txn_done), .outst_cnt(outst_cnt), .busy(busy)
    );

    always #5 wclk = ~wclk;

    function automatic logic [CMD_W-1:0] mk(input logic wr, input logic [3:0] id,
                                            input logic [31:0] addr, input logic [7:0] len);
        return {wr, id, addr, len};
    endfunction

    // Expected grant of the k-th tie after reset.
    function automatic logic rr_exp(input int k);
`ifdef WR_PRIO_EN
        return 1'b1;
`else
        return (k % 2) == 0;
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge wclk);
        #1;
    endtask

    // Called at a negedge: checks the readies and records the word that must reach the FIFO.
    task automatic expect_grant(input logic wr);
        chk("awready", {63'b0, awready}, {63'b0, wr});
        chk("arready", {63'b0, arready}, {63'b0, !wr});
        if (wr) exp_q.push_back(mk(1'b1, awid, awaddr, awlen));
        else    exp_q.push_back(mk(1'b0, arid, araddr, arlen));
    endtask

    task automatic do_reset();
        chk("drain", 64'(exp_q.size()), 64'd0);
        step();
        rst_n = 1'b0;
        awvalid = 1'b0; arvalid = 1'b0; fifo_full = 1'b0; txn_done = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // Scoreboard monitor
    always @(negedge wclk) begin
        if (rst_n && fifo_wr) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_push: got %0h expected none at %0t", fifo_wdata, $time);
            end else begin
                chk("fifo_wdata", 64'(fifo_wdata), 64'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [CMD_W-1:0] word_a;

        // Reset state and basic push
        do_reset();
        @(negedge wclk);
        chk("rst_awready", {63'b0, awready}, 64'd0);
        chk("rst_arready", {63'b0, arready}, 64'd0);
        chk("rst_fifo_wr", {63'b0, fifo_wr}, 64'd0);
        chk("rst_wdata", 64'(fifo_wdata), 64'd0);
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_cnt", 64'(outst_cnt), 64'd0);
        step();
        awvalid = 1'b1; awid = 4'd3; awaddr = 32'h0000_1000; awlen = 8'd0;
        @(negedge wclk);
        expect_grant(1'b1);
        chk("basic_no_early_wr", {63'b0, fifo_wr}, 64'd0);
        step();
        awvalid = 1'b0;
        @(negedge wclk);
        chk("basic_fifo_wr", {63'b0, fifo_wr}, 64'd1);
        chk("basic_wdata", 64'(fifo_wdata), 64'(mk(1'b1, 4'd3, 32'h1000, 8'd0)));
        chk("basic_cnt", 64'(outst_cnt), 64'd1);
        step();
        txn_done = 1'b1;
        step();
        txn_done = 1'b0;
        @(negedge wclk);
        chk("basic_retire", 64'(outst_cnt), 64'd0);
        chk("basic_idle", {63'b0, busy}, 64'd0);

        // Tie-break
        do_reset();
        step();
        awvalid = 1'b1; awid = 4'd1; awaddr = 32'h0000_2000; awlen = 8'd1;
        arvalid = 1'b1; arid = 4'd2; araddr = 32'h0000_3000; arlen = 8'd2;
        for (int k = 0; k < 4; k++) begin
            @(negedge wclk);
            expect_grant(rr_exp(k));
            step();
        end
        awvalid = 1'b0; arvalid = 1'b0;
        @(negedge wclk);
        chk("tie_cnt", 64'(outst_cnt), 64'd4);
        step();
        step();

        // FIFO full stall
        do_reset();
        step();
        awvalid = 1'b1; awid = 4'd5; awaddr = 32'h0000_4000; awlen = 8'd3;
        word_a = mk(1'b1, 4'd5, 32'h4000, 8'd3);
        @(negedge wclk);
        expect_grant(1'b1);
        step();
        awvalid = 1'b0; fifo_full = 1'b1;
        arvalid = 1'b1; arid = 4'd6; araddr = 32'h0000_6000; arlen = 8'd5;
        for (int k = 0; k < 5; k++) begin
            @(negedge wclk);
            chk("full_fifo_wr", {63'b0, fifo_wr}, 64'd0);
            chk("full_wdata", 64'(fifo_wdata), 64'(word_a));
            chk("full_arready", {63'b0, arready}, 64'd0);
            step();
        end
        fifo_full = 1'b0;
        @(negedge wclk);
        chk("unfull_push", {63'b0, fifo_wr}, 64'd1);
        expect_grant(1'b0);
        step();
        arvalid = 1'b0;
        @(negedge wclk);
        chk("unfull_push2", {63'b0, fifo_wr}, 64'd1);
        chk("unfull_cnt", 64'(outst_cnt), 64'd2);
        step();
        step();

        // Outstanding limit
        do_reset();
        step();
        awvalid = 1'b1; awid = 4'd7; awaddr = 32'h0000_5000; awlen = 8'd4;
        arvalid = 1'b1; arid = 4'd8; araddr = 32'h0000_8000; arlen = 8'd6;
        for (int k = 0; k < 8; k++) begin
            @(negedge wclk);
            expect_grant(rr_exp(k));
            step();
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge wclk);
            chk("lim_awready", {63'b0, awready}, 64'd0);
            chk("lim_arready", {63'b0, arready}, 64'd0);
            chk("lim_cnt", 64'(outst_cnt), 64'd8);
            step();
        end
        txn_done = 1'b1;
        @(negedge wclk);
        chk("lim_done_awready", {63'b0, awready}, 64'd0);
        step();
        txn_done = 1'b0;
        @(negedge wclk);
        expect_grant(1'b1);
        step();
        @(negedge wclk);
        chk("lim_again_aw", {63'b0, awready}, 64'd0);
        chk("lim_again_ar", {63'b0, arready}, 64'd0);
        chk("lim_again_cnt", 64'(outst_cnt), 64'd8);
        step();
        awvalid = 1'b0; arvalid = 1'b0;

        // Counter corners
        txn_done = 1'b1;
        step();
        txn_done = 1'b0;
        @(negedge wclk);
        chk("cnt_dec", 64'(outst_cnt), 64'd7);
        step();
        awvalid = 1'b1; txn_done = 1'b1;
        @(negedge wclk);
        expect_grant(1'b1);
        step();
        awvalid = 1'b0; txn_done = 1'b0;
        @(negedge wclk);
        chk("cnt_coincident", 64'(outst_cnt), 64'd7);
        step();
        txn_done = 1'b1;
        repeat (7) step();
        txn_done = 1'b0;
        @(negedge wclk);
        chk("cnt_zero", 64'(outst_cnt), 64'd0);
        step();
        txn_done = 1'b1;
        step();
        txn_done = 1'b0;
        @(negedge wclk);
        chk("cnt_no_wrap", 64'(outst_cnt), 64'd0);
        chk("cnt_idle", {63'b0, busy}, 64'd0);
        step();

        // Reset mid-operation
        do_reset();
        step();
        awvalid = 1'b1; awid = 4'd9; awaddr = 32'h0000_7000; awlen = 8'd2;
        for (int k = 0; k < 5; k++) begin
            @(negedge wclk);
            expect_grant(1'b1);
            step();
        end
        awvalid = 1'b0; fifo_full = 1'b1;
        @(negedge wclk);
        chk("pre_rst_cnt", 64'(outst_cnt), 64'd5);
        chk("pre_rst_busy", {63'b0, busy}, 64'd1);
        #2;
        rst_n = 1'b0;
        exp_q.delete(exp_q.size() - 1);
        #1;
        chk("arst_fifo_wr", {63'b0, fifo_wr}, 64'd0);
        chk("arst_cnt", 64'(outst_cnt), 64'd0);
        chk("arst_busy", {63'b0, busy}, 64'd0);
        chk("arst_wdata", 64'(fifo_wdata), 64'd0);
        step();
        step();
        fifo_full = 1'b0;
        rst_n = 1'b1;
        awvalid = 1'b1; arvalid = 1'b1;
        @(negedge wclk);
        expect_grant(1'b1);
        step();
        awvalid = 1'b0; arvalid = 1'b0;
        step();
        step();
        chk("final_drain", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
